// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer between NUM_REQ byte producers with packet locking.
// Optional grant watchdog is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2700
) (
    input  logic                   clk_3125,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   arb_timeout,
    output logic [1:0]             state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_HOLD      = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [NUM_REQ-1:0] grant_r;
    logic [NUM_REQ-1:0] req_ready_r;
    logic [7:0]         tx_data_r;
    logic               tx_start_r;
    logic               arb_timeout_r;
    logic               last_flag_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   owner_r;

    logic [NUM_REQ-1:0] grant_nxt_s;
    logic [NUM_REQ-1:0] req_ready_nxt_s;
    logic [7:0]         tx_data_nxt_s;
    logic               tx_start_nxt_s;
    logic               arb_timeout_nxt_s;
    logic               last_flag_nxt_s;
    logic [IDX_W-1:0]   ptr_nxt_s;
    logic [IDX_W-1:0]   owner_nxt_s;

    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               done_ok_s;
    logic               issue_s;
    logic [IDX_W-1:0]   issue_idx_s;
    logic               release_s;
    logic               timeout_fire_s;
    logic               wd_expired_s;
    logic               wd_entry_s;

    function automatic logic [NUM_REQ-1:0] onehot_f(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Round-robin search: scan farthest-to-nearest so the nearest valid index after ptr wins.
    always_comb begin
        int cand;
        cand         = 0;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand         = (int'(ptr_r) + off) % NUM_REQ;
            pick_idx_s   = req_valid[cand] ? IDX_W'(cand) : pick_idx_s;
            pick_found_s = pick_found_s | req_valid[cand];
        end
    end

    // A done pulse coinciding with our own start belongs to an earlier frame.
    always_comb begin
        done_ok_s = tx_done & ~tx_start_r;
    end

    // Watchdog counter restarts on every entry into a waiting state.
    always_comb begin
        wd_entry_s = (state_nxt_s != state_r) && (state_nxt_s != ST_IDLE);
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_r;

    // Expiry is judged on the registered count so it never depends on this cycle's next state.
    always_comb begin
        wd_expired_s = (state_r != ST_IDLE) && (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));
    end

    // Watchdog counter register.
    always_ff @(posedge clk_3125) begin
        if (!rst_n) begin
            wd_cnt_r <= '0;
        end else if (wd_entry_s) begin
            wd_cnt_r <= '0;
        end else if (state_r != ST_IDLE) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= '0;
        end
    end
`else
    logic wd_unused_s;

    // Without the watchdog the waiting states never expire.
    always_comb begin
        wd_expired_s = 1'b0;
        wd_unused_s  = wd_entry_s | (TIMEOUT_CYCLES > 0);
    end
`endif

    // State register.
    always_ff @(posedge clk_3125) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and the issue/release decisions that drive the datapath.
    always_comb begin
        state_nxt_s    = state_r;
        issue_s        = 1'b0;
        issue_idx_s    = owner_r;
        release_s      = 1'b0;
        timeout_fire_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    issue_s     = 1'b1;
                    issue_idx_s = pick_idx_s;
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (done_ok_s) begin
                    if (last_flag_r) begin
                        release_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end else if (wd_expired_s) begin
                    release_s      = 1'b1;
                    timeout_fire_s = 1'b1;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_HOLD: begin
                if (req_valid[owner_r]) begin
                    issue_s     = 1'b1;
                    issue_idx_s = owner_r;
                    state_nxt_s = ST_WAIT_DONE;
                end else if (wd_expired_s) begin
                    release_s      = 1'b1;
                    timeout_fire_s = 1'b1;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values; pulses default low so they last one cycle.
    always_comb begin
        grant_nxt_s       = grant_r;
        req_ready_nxt_s   = '0;
        tx_data_nxt_s     = tx_data_r;
        tx_start_nxt_s    = 1'b0;
        arb_timeout_nxt_s = timeout_fire_s;
        last_flag_nxt_s   = last_flag_r;
        ptr_nxt_s         = ptr_r;
        owner_nxt_s       = owner_r;
        if (issue_s) begin
            grant_nxt_s     = onehot_f(issue_idx_s);
            req_ready_nxt_s = onehot_f(issue_idx_s);
            tx_data_nxt_s   = req_data[{issue_idx_s, 3'b000} +: 8];
            tx_start_nxt_s  = 1'b1;
            last_flag_nxt_s = req_last[issue_idx_s];
            owner_nxt_s     = issue_idx_s;
        end else if (release_s) begin
            grant_nxt_s = '0;
            ptr_nxt_s   = owner_r;
        end else begin
            grant_nxt_s = grant_r;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk_3125) begin
        if (!rst_n) begin
            grant_r       <= '0;
            req_ready_r   <= '0;
            tx_data_r     <= 8'h00;
            tx_start_r    <= 1'b0;
            arb_timeout_r <= 1'b0;
            last_flag_r   <= 1'b0;
            ptr_r         <= IDX_W'(NUM_REQ - 1);
            owner_r       <= '0;
        end else begin
            grant_r       <= grant_nxt_s;
            req_ready_r   <= req_ready_nxt_s;
            tx_data_r     <= tx_data_nxt_s;
            tx_start_r    <= tx_start_nxt_s;
            arb_timeout_r <= arb_timeout_nxt_s;
            last_flag_r   <= last_flag_nxt_s;
            ptr_r         <= ptr_nxt_s;
            owner_r       <= owner_nxt_s;
        end
    end

    assign grant       = grant_r;
    assign req_ready   = req_ready_r;
    assign tx_data     = tx_data_r;
    assign tx_start    = tx_start_r;
    assign arb_timeout = arb_timeout_r;
    assign state       = state_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter; covers the watchdog when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    logic        clk_3125 = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        arb_timeout;
    logic [1:0]  state;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Expected grants: {requester index, byte}, pushed when offered, popped on tx_start.
    logic [10:0] sb_q[$];

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(100)) dut (
        .clk_3125   (clk_3125),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .arb_timeout(arb_timeout),
        .state      (state)
    );

    always #160 clk_3125 = ~clk_3125;

    task automatic tick();
        @(posedge clk_3125);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] data);
        sb_q.push_back({3'(idx), data});
    endtask

    task automatic expect_start(input string tag, input int budget);
        logic [10:0] e;
        logic [3:0]  oh;
        int k;
        k = 0;
        while (tx_start !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_start"}, 32'(tx_start), 32'd1);
        chk({tag, "_sb"}, 32'(sb_q.size() > 0), 32'd1);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 11'h7ff;
        oh = 4'b0001 << e[10:8];
        chk({tag, "_data"}, 32'(tx_data), 32'(e[7:0]));
        chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
        chk({tag, "_grant"}, 32'(grant), 32'(oh));
    endtask

    task automatic send_done(input int delay);
        repeat (delay) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_tmo"}, 32'(arb_timeout), 32'd0);
        chk({tag, "_state"}, 32'(state), 32'd0);
    endtask

    initial begin
        #(20000 * 320);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        req_last  = 4'b0000;
        tx_done   = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;

        // Single byte with exact one-cycle latency.
        req_valid = 4'b0001;
        req_data  = 32'h0000_0041;
        req_last  = 4'b0001;
        push(0, 8'h41);
        tick();
        expect_start("single", 0);
        chk("single_state", 32'(state), 32'd1);
        req_valid = 4'b0000;
        send_done(3);
        chk("single_rel_grant", 32'(grant), 32'd0);
        chk("single_rel_state", 32'(state), 32'd0);

        // Round robin from a fresh pointer.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'hA3A2_A1A0;
        req_last  = 4'b1111;
        for (int i = 0; i < 4; i++) push(i, 8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            expect_start("rr", 4);
            req_valid[i] = 1'b0;
            send_done(2);
        end
        req_valid[0] = 1'b1;
        push(0, 8'hA0);
        expect_start("rr5", 4);
        req_valid = 4'b0000;
        send_done(2);

        // Packet lock: requester 1 keeps the grant across three bytes.
        req_valid = 4'b0110;
        req_data  = 32'h0022_1000;
        req_last  = 4'b0100;
        push(1, 8'h10);
        expect_start("lock0", 4);
        req_data[15:8] = 8'h11;
        push(1, 8'h11);
        send_done(2);
        chk("lock_hold_state", 32'(state), 32'd2);
        chk("lock_hold_grant", 32'(grant), 32'b0010);
        tick();
        expect_start("lock1", 0);
        req_data[15:8] = 8'h12;
        req_last[1]    = 1'b1;
        push(1, 8'h12);
        send_done(2);
        tick();
        expect_start("lock2", 0);
        req_valid[1] = 1'b0;
        push(2, 8'h22);
        send_done(2);
        chk("lock_idle_state", 32'(state), 32'd0);
        tick();
        expect_start("lock_r2", 0);
        req_valid = 4'b0000;
        send_done(2);

        // Reset in WAIT_DONE, then a stray done.
        req_valid = 4'b0001;
        req_data  = 32'h0000_0030;
        req_last  = 4'b1111;
        push(0, 8'h30);
        expect_start("rst_pre", 4);
        req_valid = 4'b0000;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state("midrst");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("stray_state", 32'(state), 32'd0);
        chk("stray_start", 32'(tx_start), 32'd0);
        req_valid = 4'b1001;
        req_data  = 32'h5300_0050;
        push(0, 8'h50);
        expect_start("rst_r0", 4);
        req_valid[0] = 1'b0;
        push(3, 8'h53);
        send_done(2);
        expect_start("rst_r3", 4);
        req_valid = 4'b0000;
        send_done(2);

        // tx_done coinciding with tx_start is ignored.
        req_valid = 4'b0100;
        req_data  = 32'h0077_0000;
        push(2, 8'h77);
        expect_start("dds", 4);
        req_valid = 4'b0000;
        tx_done   = 1'b1;
        tick();
        tx_done   = 1'b0;
        chk("dds_wait_state", 32'(state), 32'd1);
        chk("dds_wait_grant", 32'(grant), 32'b0100);
        repeat (3) tick();
        chk("dds_still_wait", 32'(state), 32'd1);
        send_done(1);
        chk("dds_rel_state", 32'(state), 32'd0);
        chk("dds_rel_grant", 32'(grant), 32'd0);

        // Abandoned packet: requester 3 stops after a non-last byte.
        req_valid = 4'b1001;
        req_data  = 32'h5500_000F;
        req_last  = 4'b0001;
        push(3, 8'h55);
        expect_start("to_r3", 4);
        req_valid[3] = 1'b0;
        send_done(2);
        chk("to_hold_state", 32'(state), 32'd2);
        seen = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        repeat (99) begin
            tick();
            seen = seen | arb_timeout | tx_start;
        end
        chk("to_quiet", 32'(seen), 32'd0);
        tick();
        chk("to_pulse", 32'(arb_timeout), 32'd1);
        chk("to_grant", 32'(grant), 32'd0);
        chk("to_state", 32'(state), 32'd0);
        push(0, 8'h0F);
        tick();
        chk("to_pulse_end", 32'(arb_timeout), 32'd0);
        expect_start("to_r0", 0);
        req_valid = 4'b0000;
        send_done(2);
`else
        repeat (150) begin
            tick();
            seen = seen | arb_timeout | tx_start;
        end
        chk("nto_quiet", 32'(seen), 32'd0);
        chk("nto_grant", 32'(grant), 32'b1000);
        chk("nto_state", 32'(state), 32'd2);
        req_valid = 4'b0000;
`endif

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter of the MazeSolver Bot between up to `NUM_REQ` byte producers. Examples of producers are the path reporter, the sensor dump and the echo of received commands. Each producer offers one byte at a time with a valid/ready handshake. A producer keeps its grant across a multi-byte packet until it marks the last byte, so packets from different producers never interleave on the serial line. The block sits between the producers and the UART TX serializer. It drives `tx_start`/`tx_data` and consumes the serializer's `tx_done`.

## Interface
- `NUM_REQ`, 4, number of requesters (2–8).
- `TIMEOUT_CYCLES`, 2700, watchdog limit in clocks (about 100 bit times at 27 clocks/bit). Used only with `UART_ARB_TIMEOUT_EN`.
- `clk_3125`  in  1  3.125 MHz system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  requester i offers a byte.
- `req_data`  in  8*NUM_REQ  byte of requester i, at bits [8i+7:8i].
- `req_last`  in  NUM_REQ  offered byte is the last byte of requester i's packet.
- `req_ready`  out  NUM_REQ  one-cycle one-hot pulse: byte of requester i accepted.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when free.
- `tx_start`  out  1  one-cycle pulse to the serializer.
- `tx_data`  out  8  byte for the serializer; held stable until the next `tx_start`.
- `tx_done`  in  1  one-cycle pulse when the serializer has finished the stop bit.
- `arb_timeout`  out  1  one-cycle pulse when the watchdog releases a grant.
- `state`  out  2  FSM state for debug: IDLE=0, WAIT_DONE=1, HOLD=2.

## Operation
- All outputs are registered. Reset values: `req_ready`=0, `grant`=0, `tx_start`=0, `tx_data`=8'h00, `arb_timeout`=0, `state`=IDLE. Internal values: round-robin pointer `ptr`=NUM_REQ-1, `last_flag`=0, watchdog counter=0.
- **Issue action** for winner g, performed on one clock edge:
  - `grant`←onehot(g), `tx_data`←`req_data[g]`, `tx_start`←1, `req_ready`←onehot(g), `last_flag`←`req_last[g]`, `state`←WAIT_DONE.
  - `tx_start` and `req_ready` return to 0 on the following edge.
- **IDLE:** if any `req_valid` bit is set, pick the first set index searching from `ptr`+1 modulo NUM_REQ, then perform the issue action. Otherwise remain in IDLE.
- **WAIT_DONE:** wait for `tx_done`. A `tx_done` sampled while `tx_start`=1 is ignored.
  - On `tx_done` with `last_flag`=1: `grant`←0, `ptr`←g, go to IDLE.
  - On `tx_done` with `last_flag`=0: go to HOLD, `grant` unchanged.
- **HOLD:** if `req_valid[g]`=1, perform the issue action for g. All other requesters are ignored. If `req_valid[g]`=0, stay in HOLD.
- Requesters hold `req_valid`, `req_data` and `req_last` stable until they see `req_ready`. They may change them in the cycle after `req_ready`.
- `req_valid` is ignored in WAIT_DONE.
- `tx_done` is ignored in IDLE and HOLD. This covers a frame that was in flight across a reset.
- Reset asserted mid-operation returns every output and register to its reset value on that edge. The serializer is not aborted.

## Timing
- IDLE request sampled at cycle c → `tx_start`, `req_ready` and `grant` high in cycle c+1.
- `tx_done` of the final byte at cycle d → IDLE at d+1 → next `tx_start` no earlier than d+2.
- `tx_done` of a non-final byte at cycle d → HOLD at d+1 → next byte's `tx_start` at d+2 if `req_valid[g]` is already high.
- Throughput: one byte per serializer frame plus 2 clocks.

## Configuration
- **`UART_ARB_TIMEOUT_EN` defined:**
  - A counter clears on every entry to WAIT_DONE or HOLD and increments each cycle spent there.
  - If the counter reaches `TIMEOUT_CYCLES`-1 with no exit event: `grant`←0, `ptr`←g, `arb_timeout` pulses 1 cycle, go to IDLE.
  - This covers a stuck serializer and a producer that abandons a packet.
- **`UART_ARB_TIMEOUT_EN` undefined:** WAIT_DONE and HOLD wait indefinitely, no counter is built, and `arb_timeout` is tied to 0.

## Test plan
- **Single byte:** reset, then `req_valid[0]`=1, `req_data`=0x41, `req_last[0]`=1 at cycle c → `tx_start`=1, `tx_data`=0x41, `req_ready`=4'b0001, `grant`=4'b0001 at c+1. `tx_done` at d → `grant`=0 and `state`=IDLE at d+1.
- **Round robin:** all four requesters valid with `req_last`=1 and distinct bytes 0xA0–0xA3 → `tx_data` order 0xA0, 0xA1, 0xA2, 0xA3. Requester 0 is re-offered afterwards → 0xA0 is served fifth.
- **Packet lock:** requester 1 sends 0x10, 0x11, 0x12 with `req_last` only on 0x12, while requester 2 is valid throughout → `grant` stays 4'b0010 for all three bytes. Requester 2 gets `tx_start` 2 cycles after 0x12's `tx_done`.
- **Reset and stray done:** `rst_n`=0 for one cycle in WAIT_DONE → all outputs 0 on the next edge. A following stray `tx_done` leaves `state`=IDLE. Requesters 0 and 3 are then valid → requester 0 is granted first.
- **Done during start:** `tx_done` asserted in the same cycle as `tx_start` → ignored, FSM stays in WAIT_DONE until the next `tx_done`.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=100):** requester 3 sends non-last 0x55 then drops valid, with requester 0 valid → 100 cycles after entering HOLD, `arb_timeout` pulses and `grant`=0. Requester 0 gets `tx_start` 2 cycles later. With the macro undefined, `grant` stays 4'b1000 indefinitely.
